// File: rtl/uart_rx_oversampler_if.sv
// Receive-side bus of the oversampling UART receiver: serial line in,
// received word plus status pulses out.
interface uart_rx_oversampler_if #(
  parameter int unsigned DBIT = 8
);

  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;

  // Receiver side: samples the line, produces the word and status.
  modport master (
    input  rx,
    output dout,
    output rx_done_tick,
    output frame_err,
    output busy
  );

  // Consumer side: drives the line, takes the word and status.
  modport slave (
    output rx,
    input  dout,
    input  rx_done_tick,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_oversampler.sv
// UART receiver with 16x oversampling: start bit checked at mid-bit,
// data sampled every 16 ticks LSB first, stop bit checked after SB_TICK ticks.
// DBIT is expected to be at least 2.
module uart_rx_oversampler #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned DVSR    = 163
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_rx_oversampler_if.master  bus
);

  localparam int unsigned CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic            sync1_q;
  logic            rx_s_q;
  logic [CW-1:0]   cnt_q;
  logic            s_tick;
  state_t          state_q;
  logic [3:0]      s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic            done_q;
  logic            ferr_q;
  logic            busy_q;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      rx_s_q  <= sync1_q;
    end
  end

  assign s_tick = (cnt_q == CW'(DVSR - 1));

  // Free-running oversample tick divider, wraps after DVSR clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (s_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Frame FSM; pulses default low each cycle, busy tracks the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Falling edge seen: start counting toward the start-bit middle.
          if (!rx_s_q) begin
            state_q <= START;
            s_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == 4'd7) begin
              if (!rx_s_q) begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                // Line back high at mid start bit: glitch, drop silently.
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == 4'd15) begin
              s_q <= '0;
              b_q <= DBIT'({rx_s_q, b_q} >> 1);
              if (n_q == NW'(DBIT - 1)) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_q == 4'(SB_TICK - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (rx_s_q) begin
                done_q <= 1'b1;
              end else begin
                ferr_q <= 1'b1;
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout         = b_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
  assign bus.busy         = busy_q;

endmodule
